// File: rtl/srl_fifo.sv
// Single-clock FIFO on a shift-register storage array. Writes shift every entry
// up by one, and reads come from the entry that the occupancy count points at.
module srl_fifo #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] q,
    output logic             empty,
    output logic             full,
    output logic             err_ovr,
    output logic             err_und
);

    localparam int              DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] CAP = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]  srl_r [DEPTH];
    logic [ADDR_W-1:0] cnt_r;
    logic [WIDTH-1:0]  q_r;
    logic              empty_r;
    logic              full_r;
    logic              err_ovr_r;
    logic              err_und_r;

    logic              shift_s;
    logic [ADDR_W-1:0] rd_addr_s;
    logic [ADDR_W-1:0] cnt_nxt_s;
    logic [WIDTH-1:0]  q_nxt_s;
    logic              set_ovr_s;
    logic              set_und_s;

    // Next-state decode for occupancy, read data and error events.
    always_comb begin
        shift_s   = 1'b0;
        rd_addr_s = cnt_r - ONE;
        cnt_nxt_s = cnt_r;
        q_nxt_s   = q_r;
        set_ovr_s = 1'b0;
        set_und_s = 1'b0;
        // A full FIFO may still shift when a pop frees the oldest slot in the same cycle.
        if (wr_en && (!full_r || rd_en)) begin
            shift_s = 1'b1;
        end else begin
            shift_s = 1'b0;
        end
        case ({wr_en, rd_en})
            2'b10: begin
                if (full_r) begin
                    set_ovr_s = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r + ONE;
                end
            end
            2'b01: begin
                if (empty_r) begin
                    set_und_s = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r - ONE;
                    q_nxt_s   = srl_r[rd_addr_s];
                end
            end
            2'b11: begin
                // Empty read-while-write forwards the incoming word straight to q.
                if (empty_r) begin
                    q_nxt_s = d;
                end else begin
                    q_nxt_s = srl_r[rd_addr_s];
                end
            end
            default: begin
                cnt_nxt_s = cnt_r;
            end
        endcase
    end

    // Storage shift; contents are not reset since only cnt defines validity.
    always_ff @(posedge clk) begin
        if (shift_s) begin
            srl_r[0] <= d;
            for (int k = 1; k < DEPTH; k++) begin
                srl_r[k] <= srl_r[k-1];
            end
        end else begin
            srl_r <= srl_r;
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r     <= {ADDR_W{1'b0}};
            q_r       <= {WIDTH{1'b0}};
            empty_r   <= 1'b1;
            full_r    <= 1'b0;
            err_ovr_r <= 1'b0;
            err_und_r <= 1'b0;
        end else begin
            cnt_r     <= cnt_nxt_s;
            q_r       <= q_nxt_s;
            empty_r   <= (cnt_nxt_s == {ADDR_W{1'b0}});
            full_r    <= (cnt_nxt_s == CAP);
            err_ovr_r <= err_ovr_r | set_ovr_s;
            err_und_r <= err_und_r | set_und_s;
        end
    end

    assign q       = q_r;
    assign empty   = empty_r;
    assign full    = full_r;
    assign err_ovr = err_ovr_r;
    assign err_und = err_und_r;

endmodule

// File: tb/tb_srl_fifo.sv
// Directed bench for srl_fifo: stimulus queues the expected q for each read,
// and a monitor compares q one step after every edge that sampled rd_en.
module tb_srl_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] d = 8'd0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] q;
    logic       empty;
    logic       full;
    logic       err_ovr;
    logic       err_und;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q [$];

    srl_fifo #(.WIDTH(8), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .d(d), .wr_en(wr_en), .rd_en(rd_en),
        .q(q), .empty(empty), .full(full), .err_ovr(err_ovr), .err_und(err_und)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic cyc(input logic w, input logic r, input logic [7:0] dd);
        @(negedge clk);
        wr_en = w;
        rd_en = r;
        d     = dd;
        @(posedge clk);
        #2;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic rd(input logic w, input logic [7:0] dd, input logic [7:0] expv);
        exp_q.push_back(expv);
        cyc(w, 1'b1, dd);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic chk_flags(input string name, input logic e, input logic f,
                             input logic o, input logic u);
        chk({name, "_empty"}, {31'd0, empty}, {31'd0, e});
        chk({name, "_full"}, {31'd0, full}, {31'd0, f});
        chk({name, "_err_ovr"}, {31'd0, err_ovr}, {31'd0, o});
        chk({name, "_err_und"}, {31'd0, err_und}, {31'd0, u});
    endtask

    // Monitor: every non-reset edge that sampled rd_en presents a q value.
    initial begin
        logic r_s;
        logic rst_s;
        forever begin
            @(posedge clk);
            r_s   = rd_en;
            rst_s = rst;
            #1;
            if (r_s && !rst_s) begin
                if (exp_q.size() == 0) begin
                    chk("q_unexpected_read", 32'd1, 32'd0);
                end else begin
                    chk("q_data", {24'd0, q}, {24'd0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        do_reset();
        chk_flags("reset", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("reset_q", {24'd0, q}, 32'd0);

        // Fill with 128..158.
        for (int i = 0; i < 31; i++) cyc(1'b1, 1'b0, 8'(128 + i));
        chk_flags("fill", 1'b0, 1'b1, 1'b0, 1'b0);

        // Read-while-write at full.
        for (int i = 0; i < 9; i++) rd(1'b1, 8'(159 + i), 8'(128 + i));
        chk_flags("rw_full", 1'b0, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 31; i++) rd(1'b0, 8'd0, 8'(137 + i));
        chk_flags("drain", 1'b1, 1'b0, 1'b0, 1'b0);

        // Pass-through on empty, then underflow.
        rd(1'b1, 8'd255, 8'd255);
        chk_flags("passthru", 1'b1, 1'b0, 1'b0, 1'b0);
        rd(1'b0, 8'd0, 8'd255);
        chk_flags("underflow", 1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 8'd7);
        chk_flags("und_sticky", 1'b0, 1'b0, 1'b0, 1'b1);
        rd(1'b0, 8'd0, 8'd7);
        chk_flags("und_sticky2", 1'b1, 1'b0, 1'b0, 1'b1);

        // Overflow: dropped word never reaches q.
        do_reset();
        chk_flags("reset2", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("reset2_q", {24'd0, q}, 32'd0);
        for (int i = 0; i < 31; i++) cyc(1'b1, 1'b0, 8'(i));
        chk_flags("fill2", 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 8'd99);
        chk_flags("overflow", 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 31; i++) rd(1'b0, 8'd0, 8'(i));
        chk_flags("drain2", 1'b1, 1'b0, 1'b1, 1'b0);

        // Alternate RW / WRITE until full, then drain.
        do_reset();
        for (int i = 0; i < 62; i++) begin
            if (i % 2 == 0) rd(1'b1, 8'(i), 8'(i / 2));
            else            cyc(1'b1, 1'b0, 8'(i));
        end
        chk_flags("alt_full", 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 31; i++) rd(1'b0, 8'd0, 8'(31 + i));
        chk_flags("alt_drain", 1'b1, 1'b0, 1'b0, 1'b0);

        // Reset while partly full with error flags set.
        rd(1'b0, 8'd0, 8'(61));
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'(200 + i));
        rd(1'b0, 8'd0, 8'd200);
        chk_flags("pre_rst", 1'b0, 1'b0, 1'b0, 1'b1);
        do_reset();
        chk_flags("mid_rst", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("mid_rst_q", {24'd0, q}, 32'd0);
        cyc(1'b1, 1'b0, 8'd42);
        rd(1'b0, 8'd0, 8'd42);
        chk_flags("post_rst", 1'b1, 1'b0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard_left", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
